sync_fifo_ctrl: RTL and testbench
=================================

// Module: sync_fifo_ctrl
// PURPOSE
//  Single-clock pointer/flag controller for the fifo_storage memory, with both storage clocks tied to clk.
//  Accepts push/pop requests and drives storage w_en/w_addr/r_en/r_addr.
//  Tracks occupancy and reports full/empty, almost-full/almost-empty, overflow/underflow and count.
//  Read data and rd_valid come from the storage itself, one cycle after r_en.
// PARAMETERS
//  FIFO_DEPTH  8  entries in storage; must equal 2**PTR_WIDTH
//  PTR_WIDTH   3  storage address width
//  AFULL_LVL   6  almost_full asserted when count >= AFULL_LVL (1..FIFO_DEPTH)
//  AEMPTY_LVL  1  almost_empty asserted when count <= AEMPTY_LVL (0..FIFO_DEPTH-1)
// PORTS
//  clk           in   1            single clock; also drives storage wr_clk and rd_clk
//  rstn          in   1            asynchronous active-low reset
//  push          in   1            write request; data presented to storage wr_data the same cycle
//  pop           in   1            read request
//  flush         in   1            synchronous clear of all FIFO state
//  w_en          out  1            storage write enable
//  w_addr        out  PTR_WIDTH    storage write address
//  r_en          out  1            storage read enable
//  r_addr        out  PTR_WIDTH    storage read address
//  full          out  1            count == FIFO_DEPTH
//  empty         out  1            count == 0
//  almost_full   out  1            count >= AFULL_LVL
//  almost_empty  out  1            count <= AEMPTY_LVL
//  count         out  PTR_WIDTH+1  current occupancy, 0..FIFO_DEPTH
//  overflow      out  1            one-cycle pulse: push was rejected
//  underflow     out  1            one-cycle pulse: pop was rejected
// BEHAVIOUR
//  Pointers
//   - Internal wr_ptr and rd_ptr are PTR_WIDTH+1 bits wide; the MSB is the wrap bit.
//   - w_addr and r_addr are the PTR_WIDTH LSBs of the pointers; they are register outputs.
//   - Full is detected when the pointer MSBs differ and the LSBs are equal.
//   - Empty is detected when the pointers are equal.
//  Acceptance (combinational from registered flags)
//   - w_en = push & ~full & ~flush.
//   - r_en = pop & ~empty & ~flush.
//   - When full, push is rejected even if pop is also asserted.
//   - When empty, pop is rejected even if push is also asserted.
//  Update on posedge clk (when not in reset)
//   - w_en increments wr_ptr; r_en increments rd_ptr.
//   - count_next = count + w_en - r_en, so a simultaneous accepted push and pop leave count unchanged.
//   - full, empty, almost_full and almost_empty are registered from count_next.
//   - Pointer wrap: the LSBs roll from FIFO_DEPTH-1 to 0 and the MSB toggles.
//  Error pulses
//   - overflow  <= push & full & ~flush.
//   - underflow <= pop & empty & ~flush.
//   - Each pulse is high for exactly one cycle per rejected request.
//  Flush
//   - Flush has priority over push and pop in the same cycle.
//   - Next cycle: pointers 0, count 0, empty 1, full 0, overflow/underflow 0.
//  Read latency
//   - Data for r_en issued at edge N appears on storage rd_data with rd_valid=1 after edge N.
//   - The controller does not track this latency.
//  Reset (async, rstn=0)
//   - Pointers 0, count 0, empty 1, full 0, almost_empty 1.
//   - almost_full = (AFULL_LVL==0).
//   - overflow 0, underflow 0.
//   - Reset mid-operation discards all contents; storage memory is not cleared.
// TESTING
//  1. Fill: 8 consecutive pushes from reset -> after the 8th edge full=1, count=8, almost_full=1 (asserted after the 6th); w_addr sequence 0..7.
//  2. Overflow: at count=8, push=1 and pop=1 for one cycle -> w_en=0, r_en=1, overflow pulses 1 cycle, count=7.
//  3. Underflow: from reset, pop=1 and push=1 -> r_en=0, w_en=1, underflow pulses 1 cycle, count=1, empty=0.
//  4. Wrap and order: push 20 values 0x00..0x13 interleaved with pops -> addresses wrap 7->0 and storage rd_data returns 0x00..0x13 in order with rd_valid.
//  5. Flush: at count=5, flush=1 with push=1 -> w_en=0; next cycle count=0, empty=1, w_addr=0, r_addr=0.
//  6. Reset mid-op: assert rstn=0 asynchronously at count=3 -> count=0 and empty=1 immediately; the first push after release writes address 0.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// Purpose : single-clock pointer/flag controller driving a dual-port fifo_storage memory.
// Latency : w_en/r_en are combinational from push/pop; pointers, count and flags update on the next edge.
// Backpr. : push is dropped (overflow pulse) while full, pop is dropped (underflow pulse) while empty.
module sync_fifo_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int PTR_WIDTH  = 3,
    parameter int AFULL_LVL  = 6,
    parameter int AEMPTY_LVL = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    output logic                 w_en,
    output logic [PTR_WIDTH-1:0] w_addr,
    output logic                 r_en,
    output logic [PTR_WIDTH-1:0] r_addr,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int CW = PTR_WIDTH + 1;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [CW-1:0] wr_ptr_next;
    logic [CW-1:0] rd_ptr_next;
    logic [CW-1:0] count_next;
    logic          full_next;
    logic          empty_next;

    // Acceptance is gated only by registered flags, so no comb path from pop to w_en.
    assign w_en   = push & ~full  & ~flush;
    assign r_en   = pop  & ~empty & ~flush;
    assign w_addr = wr_ptr[PTR_WIDTH-1:0];
    assign r_addr = rd_ptr[PTR_WIDTH-1:0];

    // Next-state pointers and occupancy; flush wins over any accepted request.
    always_comb begin
        wr_ptr_next = wr_ptr + CW'(w_en);
        rd_ptr_next = rd_ptr + CW'(r_en);
        count_next  = count + CW'(w_en) - CW'(r_en);
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end
        full_next  = (wr_ptr_next[PTR_WIDTH] != rd_ptr_next[PTR_WIDTH]) &&
                     (wr_ptr_next[PTR_WIDTH-1:0] == rd_ptr_next[PTR_WIDTH-1:0]);
        empty_next = (wr_ptr_next == rd_ptr_next);
    end

    // Register pointers, occupancy, level flags and the one-cycle error pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= (AFULL_LVL == 0);
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_next;
            rd_ptr       <= rd_ptr_next;
            count        <= count_next;
            full         <= full_next;
            empty        <= empty_next;
            almost_full  <= (count_next >= CW'(AFULL_LVL));
            almost_empty <= (count_next <= CW'(AEMPTY_LVL));
            overflow     <= push & full  & ~flush;
            underflow    <= pop  & empty & ~flush;
        end
    end

    // Occupancy can never exceed the storage depth.
    a_count_bound : assert property (@(posedge clk) disable iff (!rstn)
        count <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Purpose : directed vector table plus hand-written corner sequences for sync_fifo_ctrl.
// Latency : inputs driven 1ns after posedge, comb outputs checked 1ns later, registers 1ns after next posedge.
// Backpr. : a behavioural storage model returns read data one cycle after r_en.
module tb_sync_fifo_ctrl;

    localparam int PW = 3;

    typedef struct {
        int push, pop, flush;
        int wen, ren;
        int cnt, full, empty, af, ae, ovf, udf, wa, ra;
    } vec_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          push, pop, flush;
    logic          w_en, r_en;
    logic [PW-1:0] w_addr, r_addr;
    logic          full, empty, almost_full, almost_empty;
    logic [PW:0]   count;
    logic          overflow, underflow;

    logic [7:0]    wr_data;
    logic [7:0]    mem [8];
    logic [7:0]    rd_data;
    logic          rd_valid;

    int   n_cmp = 0;
    int   n_err = 0;
    vec_t tbl [20];
    int   pushed, rcv, cyc;
    logic acc, wrap_pt;

    sync_fifo_ctrl #(
        .FIFO_DEPTH (8),
        .PTR_WIDTH  (PW),
        .AFULL_LVL  (6),
        .AEMPTY_LVL (1)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .push         (push),
        .pop          (pop),
        .flush        (flush),
        .w_en         (w_en),
        .w_addr       (w_addr),
        .r_en         (r_en),
        .r_addr       (r_addr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Storage model: write on w_en, registered read with rd_valid one cycle after r_en.
    always @(posedge clk) begin
        if (w_en) mem[w_addr] <= wr_data;
        rd_valid <= r_en;
        if (r_en) rd_data <= mem[r_addr];
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
        rstn  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic chk_regs(input string tag, input vec_t v);
        chk({tag, ".count"},     int'(count),        v.cnt);
        chk({tag, ".full"},      int'(full),         v.full);
        chk({tag, ".empty"},     int'(empty),        v.empty);
        chk({tag, ".afull"},     int'(almost_full),  v.af);
        chk({tag, ".aempty"},    int'(almost_empty), v.ae);
        chk({tag, ".overflow"},  int'(overflow),     v.ovf);
        chk({tag, ".underflow"}, int'(underflow),    v.udf);
        chk({tag, ".w_addr"},    int'(w_addr),       v.wa);
        chk({tag, ".r_addr"},    int'(r_addr),       v.ra);
    endtask

    initial begin
        wr_data = 8'h00;
        // Fill from reset: count k+1, almost_full from the 6th push, full on the 8th.
        for (int k = 0; k < 8; k++)
            tbl[k] = '{1,0,0, 1,0, k+1, int'(k == 7), 0, int'(k >= 5), int'(k == 0), 0,0, (k+1) % 8, 0};
        //          push pop fl wen ren cnt full emp af ae ovf udf wa ra
        tbl[8]  = '{1,1,0, 0,1, 7, 0,0,1,0, 1,0, 0,1};   // full: push rejected, pop taken
        tbl[9]  = '{0,0,0, 0,0, 7, 0,0,1,0, 0,0, 0,1};   // overflow pulse drops
        tbl[10] = '{1,1,0, 1,1, 7, 0,0,1,0, 0,0, 1,2};   // simultaneous accept, count steady
        tbl[11] = '{0,1,0, 0,1, 6, 0,0,1,0, 0,0, 1,3};
        tbl[12] = '{0,1,0, 0,1, 5, 0,0,0,0, 0,0, 1,4};   // almost_full releases below 6
        tbl[13] = '{1,0,1, 0,0, 0, 0,1,0,1, 0,0, 0,0};   // flush beats push
        tbl[14] = '{1,1,0, 1,0, 1, 0,0,0,1, 0,1, 1,0};   // empty: pop rejected, push taken
        tbl[15] = '{0,1,0, 0,1, 0, 0,1,0,1, 0,0, 1,1};
        tbl[16] = '{0,1,0, 0,0, 0, 0,1,0,1, 0,1, 1,1};   // underflow
        tbl[17] = '{0,1,0, 0,0, 0, 0,1,0,1, 0,1, 1,1};   // second rejected pop, second pulse
        tbl[18] = '{0,1,1, 0,0, 0, 0,1,0,1, 0,0, 0,0};   // flush masks underflow
        tbl[19] = '{0,0,0, 0,0, 0, 0,1,0,1, 0,0, 0,0};

        do_reset();
        chk_regs("reset", '{0,0,0, 0,0, 0, 0,1,0,1, 0,0, 0,0});

        for (int i = 0; i < 20; i++) begin
            push  = tbl[i].push  != 0;
            pop   = tbl[i].pop   != 0;
            flush = tbl[i].flush != 0;
            #1;
            chk($sformatf("v%0d.w_en", i), int'(w_en), tbl[i].wen);
            chk($sformatf("v%0d.r_en", i), int'(r_en), tbl[i].ren);
            @(posedge clk);
            #1;
            chk_regs($sformatf("v%0d", i), tbl[i]);
        end

        // Underflow straight out of reset with a concurrent push.
        do_reset();
        push = 1'b1;
        pop  = 1'b1;
        #1;
        chk("rst_udf.w_en", int'(w_en), 1);
        chk("rst_udf.r_en", int'(r_en), 0);
        @(posedge clk);
        #1;
        chk("rst_udf.underflow", int'(underflow), 1);
        chk("rst_udf.count",     int'(count),     1);
        chk("rst_udf.empty",     int'(empty),     0);
        push = 1'b0;
        pop  = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_udf.pulse_end", int'(underflow), 0);

        // Wrap and ordering: 20 bytes through the 8-entry storage model.
        do_reset();
        pushed = 0;
        rcv    = 0;
        cyc    = 0;
        while (rcv < 20 && cyc < 300) begin
            push    = (pushed < 20);
            wr_data = 8'(pushed);
            pop     = (cyc % 3 != 0) || (pushed >= 20);
            #1;
            acc     = w_en;
            wrap_pt = w_en && (w_addr == 3'd7);
            @(posedge clk);
            #1;
            if (acc) pushed++;
            if (wrap_pt) chk("wrap.w_addr", int'(w_addr), 0);
            if (rd_valid) begin
                chk($sformatf("order.rd_data%0d", rcv), int'(rd_data), rcv);
                rcv++;
            end
            cyc++;
        end
        push = 1'b0;
        pop  = 1'b0;
        chk("order.pushed",   pushed, 20);
        chk("order.received", rcv,    20);
        chk("order.empty",    int'(empty), 1);

        // Asynchronous reset in the middle of a cycle at count 3.
        do_reset();
        push = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        push = 1'b0;
        chk("midrst.count_before", int'(count), 3);
        #3 rstn = 1'b0;
        #1;
        chk("midrst.count", int'(count), 0);
        chk("midrst.empty", int'(empty), 1);
        chk("midrst.w_addr", int'(w_addr), 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        push = 1'b1;
        #1;
        chk("midrst.first_w_en",   int'(w_en),   1);
        chk("midrst.first_w_addr", int'(w_addr), 0);
        @(posedge clk);
        #1;
        push = 1'b0;
        chk("midrst.count_after", int'(count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
